// File: rtl/comp_eq.sv
// Equality / magnitude comparator: combinational equal flag and XOR difference, registered
// eq/lt/gt with valid, saturating equal-hit counter and sticky mismatch. Option: COMP_SIGNED_EN.
module comp_eq #(
  parameter int width = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [width-1:0] a_i,
  input  logic [width-1:0] b_i,
  output logic             equal_o,
  output logic [width-1:0] diff_o,
  input  logic             valid_i,
  input  logic             clr_i,
`ifdef COMP_SIGNED_EN
  input  logic             signed_i,
`endif
  output logic             valid_o,
  output logic             eq_q_o,
  output logic             lt_q_o,
  output logic             gt_q_o,
  output logic [15:0]      eq_cnt_o,
  output logic             mismatch_o
);

  // valid_i is a sample request with no back-pressure: every cycle it is high is accepted,
  // and valid_o qualifies eq/lt/gt_q_o exactly one cycle later.

  localparam logic [width-1:0] msb_mask = width'(1) << (width - 1);

  logic             sgn_sel;
  logic [width-1:0] a_k;
  logic [width-1:0] b_k;
  logic             lt_c;
  logic             gt_c;

`ifdef COMP_SIGNED_EN
  assign sgn_sel = signed_i;
`else
  assign sgn_sel = 1'b0;
`endif

  assign diff_o  = a_i ^ b_i;
  assign equal_o = (a_i == b_i);

  // Inverting the sign bit maps two's-complement order onto unsigned order.
  assign a_k  = sgn_sel ? (a_i ^ msb_mask) : a_i;
  assign b_k  = sgn_sel ? (b_i ^ msb_mask) : b_i;
  assign lt_c = (a_k < b_k);
  assign gt_c = (a_k > b_k);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_o <= 1'b0;
      eq_q_o  <= 1'b0;
      lt_q_o  <= 1'b0;
      gt_q_o  <= 1'b0;
    end else begin
      valid_o <= valid_i;
      if (valid_i) begin
        eq_q_o <= equal_o;
        lt_q_o <= lt_c;
        gt_q_o <= gt_c;
      end
    end
  end

  // Clear overrides a same-cycle sample for the counter and sticky flag only.
  always_ff @(posedge clk_i) begin
    if (rst_i || clr_i) begin
      eq_cnt_o   <= 16'h0000;
      mismatch_o <= 1'b0;
    end else if (valid_i) begin
      if (equal_o && (eq_cnt_o != 16'hFFFF))
        eq_cnt_o <= eq_cnt_o + 16'd1;
      if (!equal_o)
        mismatch_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_comp_eq.sv
// Directed bench for comp_eq (width 8): combinational checks with the clock stopped, then
// clocked steps checked against a reference model and an expected-result queue.
module tb_comp_eq;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         clk_en = 1'b0;
  logic         rst_i = 1'b0;
  logic [W-1:0] a_i = '0;
  logic [W-1:0] b_i = '0;
  logic         valid_i = 1'b0;
  logic         clr_i = 1'b0;
  logic         signed_i = 1'b0;
  logic         equal_o;
  logic [W-1:0] diff_o;
  logic         valid_o;
  logic         eq_q_o;
  logic         lt_q_o;
  logic         gt_q_o;
  logic [15:0]  eq_cnt_o;
  logic         mismatch_o;

  int n_checks = 0;
  int n_fail = 0;

  // scoreboard: {eq, lt, gt} pushed per accepted sample, popped when valid_o is seen
  logic [2:0]   exp_q[$];
  logic [2:0]   last_flags = 3'b000;
  logic         exp_valid = 1'b0;
  logic [15:0]  exp_cnt = 16'h0000;
  logic         exp_mm = 1'b0;

  comp_eq #(.width(W)) dut (
    .clk_i     (clk),
    .rst_i     (rst_i),
    .a_i       (a_i),
    .b_i       (b_i),
    .equal_o   (equal_o),
    .diff_o    (diff_o),
    .valid_i   (valid_i),
    .clr_i     (clr_i),
`ifdef COMP_SIGNED_EN
    .signed_i  (signed_i),
`endif
    .valid_o   (valid_o),
    .eq_q_o    (eq_q_o),
    .lt_q_o    (lt_q_o),
    .gt_q_o    (gt_q_o),
    .eq_cnt_o  (eq_cnt_o),
    .mismatch_o(mismatch_o)
  );

  always #5 clk = clk_en ? ~clk : clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [2:0] ref_cmp(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic sgn);
    int sa;
    int sb;
    sa = int'(a);
    sb = int'(b);
`ifdef COMP_SIGNED_EN
    if (sgn) begin
      sa = int'($signed(a));
      sb = int'($signed(b));
    end
`endif
    if (sa == sb) return 3'b100;
    if (sa < sb)  return 3'b010;
    return 3'b001;
  endfunction

  task automatic comb_check(input logic [W-1:0] a, input logic [W-1:0] b);
    a_i = a;
    b_i = b;
    #10;
    check("equal_o", equal_o, a == b);
    check("diff_o", diff_o, a ^ b);
  endtask

  // One clock: drive on the falling edge, update the model at the rising edge, check 1 ns later.
  task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic v,
                      input logic c, input logic r, input logic sgn, input logic full);
    logic [2:0] got;
    @(negedge clk);
    a_i = a; b_i = b; valid_i = v; clr_i = c; rst_i = r; signed_i = sgn;
    #1;
    if (full) begin
      check("equal_o_live", equal_o, a == b);
      check("diff_o_live", diff_o, a ^ b);
    end
    if (v && !r) exp_q.push_back(ref_cmp(a, b, sgn));
    if (r) begin
      exp_q.delete();
      exp_valid = 1'b0; last_flags = 3'b000; exp_cnt = 16'h0000; exp_mm = 1'b0;
    end else begin
      exp_valid = v;
      if (c) begin
        exp_cnt = 16'h0000; exp_mm = 1'b0;
      end else if (v) begin
        if (a == b && exp_cnt != 16'hFFFF) exp_cnt = exp_cnt + 16'd1;
        if (a != b) exp_mm = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (full || valid_o !== exp_valid) check("valid_o", valid_o, exp_valid);
    if (valid_o === 1'b1) begin
      if (exp_q.size() == 0) check("sb_underflow", 1, 0);
      else last_flags = exp_q.pop_front();
    end
    got = {eq_q_o, lt_q_o, gt_q_o};
    if (full || got !== last_flags) check("eq_lt_gt", got, last_flags);
    if (full || eq_cnt_o !== exp_cnt) check("eq_cnt_o", eq_cnt_o, exp_cnt);
    if (full || mismatch_o !== exp_mm) check("mismatch_o", mismatch_o, exp_mm);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;

    // combinational path with the clock stopped and registers never reset
    comb_check(8'b10101010, 8'b10101010);
    comb_check(8'b11110000, 8'b00001111);
    comb_check(8'b00000000, 8'b00000000);
    comb_check(8'b10000001, 8'b10000000);

    clk_en = 1'b1;
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h10, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h33, 8'h33, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'hF0, 8'h0F, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h01, 8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'hFF, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
`ifdef COMP_SIGNED_EN
    step(8'h80, 8'h01, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'h7F, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    step(8'hFE, 8'hFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
`endif

    // clear and sample in the same cycle
    step(8'h5A, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    step(8'h5A, 8'h5B, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 60; i++) begin
      ra = W'($urandom_range(0, 255));
      rb = ($urandom_range(0, 2) == 0) ? ra : W'($urandom_range(0, 255));
      step(ra, rb, $urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0, 1'b0,
           $urandom_range(0, 1) == 1, 1'b1);
    end

    // reset mid-operation with a sample presented
    step(8'h12, 8'h34, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h44, 8'h44, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1);
    step(8'h44, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // saturation: 65537 equal samples, then the counter must hold at 0xFFFF
    step(8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 65537; i++) begin
      ra = W'(i);
      step(ra, ra, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    check("sat_cnt", eq_cnt_o, 16'hFFFF);
    step(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'hA5, 8'hA5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    check("sat_hold", eq_cnt_o, 16'hFFFF);
    step(8'hA5, 8'hA4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(8'h00, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    check("sb_drained", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/comp_eq.md
# comp_eq

Parameterised magnitude/equality comparator for the calculator datapath. It drives a purely combinational equality flag, used directly by the ALU flag logic, alongside a registered compare result with valid qualification. It also keeps a saturating equal-hit counter and a sticky mismatch flag for the status block. It sits between the operand registers and the flag/status logic.

## Interface
Parameters:
- `width`, default 8, operand width in bits; legal range 1..64.

Ports:
- `clk_i`  input  1  system clock; all registers update on the rising edge.
- `rst_i`  input  1  reset; one clock, synchronous, active-high.
- `a_i`  input  width  operand A.
- `b_i`  input  width  operand B.
- `equal_o`  output  1  combinational, 1 when `a_i == b_i` (all bits).
- `diff_o`  output  width  combinational `a_i ^ b_i`.
- `valid_i`  input  1  sample request for the registered compare.
- `clr_i`  input  1  synchronous clear of counter and sticky flag.
- `signed_i`  input  1  two's-complement magnitude compare select; present only with `COMP_SIGNED_EN`.
- `valid_o`  output  1  registered, high one cycle after an accepted `valid_i`.
- `eq_q_o`  output  1  registered equal result.
- `lt_q_o`  output  1  registered A < B result.
- `gt_q_o`  output  1  registered A > B result.
- `eq_cnt_o`  output  16  saturating count of accepted samples with A == B.
- `mismatch_o`  output  1  sticky, set by any accepted sample with A != B.

## Operation
- `equal_o` and `diff_o` are pure functions of `a_i` and `b_i`. They do not depend on `clk_i` or `rst_i` and are valid with the clock stopped.
- Each cycle, when `valid_i` is high:
  - `eq_q_o`, `lt_q_o` and `gt_q_o` capture the compare of the current `a_i` and `b_i`.
  - Exactly one of the three is 1.
  - `valid_o` is 1 in the next cycle.
- When `valid_i` is low, `valid_o` goes to 0 next cycle and `eq/lt/gt_q_o` hold their last values.
- Magnitude compare is unsigned unless `signed_i`=1 and `COMP_SIGNED_EN` is defined.
- Equality is identical for signed and unsigned operands.
- `eq_cnt_o` increments by 1 per accepted equal sample and saturates at 0xFFFF. It does not wrap.
- `mismatch_o` sets on an accepted unequal sample and stays set until `clr_i` or `rst_i`.
- `clr_i`=1 zeroes `eq_cnt_o` and `mismatch_o` next cycle.
- If `clr_i` and `valid_i` are high in the same cycle:
  - The clear wins for the counter and the sticky flag; the sample is not counted.
  - The registered compare outputs and `valid_o` still update from that sample.
- `width`=1 is legal: `lt_q_o` = ~a & b (unsigned).

## Timing
- `equal_o` and `diff_o` have zero-cycle latency: combinational paths from `a_i`/`b_i` only.
- Registered compare latency is 1 cycle from `valid_i` to `valid_o`/`eq/lt/gt_q_o`.
- Counter and sticky latency is 1 cycle.
- Reset values (with `rst_i` high at a clock edge) are all 0:
  - `valid_o`, `eq_q_o`, `lt_q_o`, `gt_q_o`, `eq_cnt_o` and `mismatch_o` = 0.
- `rst_i` takes priority over `valid_i` and `clr_i`. A sample presented in a reset cycle is discarded.
- Reset does not affect `equal_o` or `diff_o`.
- There is no handshake back-pressure: every `valid_i` cycle is accepted.

## Configuration
- `COMP_SIGNED_EN` defined:
  - The `signed_i` port exists.
  - With `signed_i`=1, `lt_q_o`/`gt_q_o` use two's-complement ordering of `width`-bit operands.
- `COMP_SIGNED_EN` undefined:
  - The `signed_i` port is absent.
  - All magnitude compares are unsigned.
  - `equal_o`, `diff_o` and the counter are unchanged.

## Test plan
- Combinational equality, width=8, no clock, outputs checked 10 ns after each change:
  - a=10101010, b=10101010 -> `equal_o`=1, `diff_o`=0.
  - a=11110000, b=00001111 -> `equal_o`=0, `diff_o`=11111111.
  - a=00000000, b=00000000 -> `equal_o`=1.
  - a=10000001, b=10000000 -> `equal_o`=0, `diff_o`=00000001.
- Registered compare: `valid_i`=1 for a=0x10, b=0x20 -> next cycle `valid_o`=1, `lt_q_o`=1, `eq_q_o`=0, `gt_q_o`=0, `mismatch_o`=1.
- Signed mode (`COMP_SIGNED_EN`, `signed_i`=1): a=0x80, b=0x01 -> `lt_q_o`=1. With `signed_i`=0 -> `gt_q_o`=1.
- Counter saturation: 65537 accepted equal samples -> `eq_cnt_o`=0xFFFF and it stays there.
- Simultaneous clear: `clr_i`=1 and `valid_i`=1 with a=b -> next cycle `eq_cnt_o`=0, `mismatch_o`=0, `eq_q_o`=1, `valid_o`=1.
- Reset mid-operation: `rst_i` pulsed while `valid_i`=1 -> next cycle all registered outputs 0 and `equal_o` still tracks the inputs.
